lpc_periph_mc: RTL and testbench
================================

Name: lpc_periph_mc

Overview:
Parametrised next-generation LPC peripheral target. Decodes LPC I/O, TPM-locality (START 0101) and optional 32-bit memory cycles against configurable address windows. Forwards each claimed byte access to a data provider over a req/ack handshake. Adds SYNC timeout with error-SYNC reporting and explicit abort signalling. Sits between the LAD pad tristate (top level) and the TPM/register back end.

Parameters:
IO_EN, 1, claim LPC I/O cycles (START 0000, cyctype 000x)
TPM_EN, 1, claim TPM cycles (START 0101, cyctype 000x)
MEM_EN, 0, claim memory cycles (START 0000, cyctype 010x, 32-bit address)
IO_BASE, 16'h0000, I/O window base
IO_MASK, 16'hFF00, I/O window compare mask
MEM_BASE, 32'hFED4_0000, memory window base
MEM_MASK, 32'hFFFF_0000, memory window compare mask
MAX_WAIT, 64, SYNC clocks before error SYNC; 0 = never time out

Ports:
clk_i  in  1  LPC clock; all logic on rising edge
rst_i  in  1  synchronous reset, active high
lframe_i  in  1  LFRAME#, active low
lad_i  in  4  LAD sampled value
lad_o  out  4  LAD drive value, registered
lad_oe  out  1  LAD output enable, registered
req_o  out  1  access request to provider
req_we_o  out  1  1 = write, 0 = read; valid while req_o
req_type_o  out  2  00 I/O, 01 TPM, 10 memory
req_addr_o  out  32  byte address, zero-extended for 16-bit cycles
req_wdata_o  out  8  write data
req_ack_i  in  1  single-cycle completion strobe
req_err_i  in  1  qualifies req_ack_i: respond with error SYNC
req_rdata_i  in  8  read data, valid with req_ack_i
cycle_abort_o  out  1  one-clock pulse: claimed cycle aborted by LFRAME#
timeout_o  out  1  one-clock pulse: SYNC timeout fired

Behaviour:
- Reset: state IDLE; all outputs 0; wait counter 0; latched data 0.
- IDLE: lframe_i=0 and lad_i = 0000 or 0101 -> START (latch start code). Other codes ignored.
- START: lframe_i=0 re-latches the code (an invalid code -> IDLE). On lframe_i=1, lad_i = cyctype; bit1 = direction (1 write). Claim only enabled type/start combinations, else IDLE. Nibble counter = 3 (16-bit) or 7 (32-bit).
- ADDR: shift in address MSB-nibble first. After the last nibble, check the window; TPM is always claimed when TPM_EN. Miss -> IDLE, LAD never driven. Hit: write -> WDATA, read -> TAR1.
- WDATA: 2 clocks, low nibble first -> TAR1.
- req_o rises on entry to TAR1; addr/we/type/wdata are stable until req_o falls. req_o falls on the edge after req_ack_i is sampled high. Ack while req_o=0 is ignored. Ack in TAR1/TAR2 is legal and is latched.
- TAR1, TAR2: lad_oe=0.
- SYNC: lad_oe=1. Drive 0110 (long wait) until an ack is latched, then 0000 (ready) or 1010 (error if req_err_i). The wait counter increments each SYNC clock. When counter = MAX_WAIT with no ack: drive 1010, pulse timeout_o, drop req_o (this is the cancel indication). A later ack is ignored. Ack and timeout on the same clock: ack wins.
- After a ready/error SYNC: read -> RDATA (2 clocks: rdata[3:0], rdata[7:4]; 8'hFF after error/timeout); write -> FTAR.
- FTAR: one clock drive 1111, then lad_oe=0 -> IDLE.
- Abort: lframe_i=0 in any claimed state after START: next edge lad_oe=0, req_o=0, cycle_abort_o pulse, then START if lad_i is a valid code, else IDLE. Abort beats a simultaneous ack.
- Reset mid-cycle: same as reset value; no abort pulse.

Decomposition:
- lpc_defines package: START codes (0000, 0101), cyctype encodings, SYNC codes (0000, 0110, 1010), req_type encodings, FSM state enum.
- Sub-module lpc_wait_timer: counter of width $clog2(MAX_WAIT+1) with clear, enable and expire outputs; MAX_WAIT=0 ties expire low.

Test Plan:
- I/O read 0x0080 (IO_BASE=0x0000, IO_MASK=0xFF00), ack in TAR1 with rdata 0xA5 -> SYNC 0000 at first SYNC clock, LAD 0101 then 1010, FTAR 1111, req_type 00.
- TPM write 0x0F00 data 0x3C, ack after 5 SYNC clocks -> five 0110 nibbles, then 0000; req_wdata_o=0x3C, req_type 01, req_o held exactly until the ack edge.
- I/O read 0x0300, outside window -> lad_oe never asserted, req_o never asserted.
- MEM_EN=1, memory read 0xFED4_0024, no ack, MAX_WAIT=4 -> 4 clocks of 0110, then 1010, timeout_o pulse, data FF; a later ack is ignored.
- lframe_i=0 during SYNC with lad_i=0000 -> next clock lad_oe=0, req_o=0, cycle_abort_o=1, state START.
- rst_i during RDATA -> next edge all outputs 0; a following I/O write completes normally.

Source files
------------

// File: rtl/lpc_defines.sv
// Shared encodings for the LPC peripheral target: START codes, cycle types,
// SYNC nibbles, provider request types and the bus-phase state enum.
package lpc_defines;

  localparam logic [3:0] START_LPC = 4'b0000;
  localparam logic [3:0] START_TPM = 4'b0101;

  // cyctype[3:2]; cyctype[1] is the direction (1 = write)
  localparam logic [1:0] CT_IO  = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;
  localparam logic [3:0] LAD_TAR    = 4'b1111;

  localparam logic [1:0] RT_IO  = 2'b00;
  localparam logic [1:0] RT_TPM = 2'b01;
  localparam logic [1:0] RT_MEM = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_WDATA,
    ST_TAR1,
    ST_TAR2,
    ST_SYNC,
    ST_RDATA,
    ST_FTAR
  } lpc_state_e;

  function automatic logic valid_start(input logic [3:0] code);
    return (code == START_LPC) || (code == START_TPM);
  endfunction

endpackage

// File: rtl/lpc_wait_timer.sv
// SYNC wait timer: counts enabled clocks since the last clear. expire_o is
// raised on the enabled clock that brings the count to MAX_WAIT, so the
// caller can switch to error SYNC on the following clock.
module lpc_wait_timer #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise saturating increment while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (MAX_WAIT == 0) begin : g_never
    assign expire_o = 1'b0;
  end else begin : g_expire
    assign expire_o = en_i && !clr_i && (cnt_q == LAST);
  end

endmodule

// File: rtl/lpc_periph_mc.sv
// LPC peripheral target: decodes I/O, TPM and optional memory cycles,
// forwards claimed byte accesses to a provider over req/ack, and answers
// with registered LAD drive including long-wait, error SYNC and timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for LFRAME# with a START code
// START    | START latched; LFRAME# high marks the cyctype nibble
// ADDR     | shifting address nibbles, MSB first
// WDATA    | write data, low nibble then high nibble
// TAR1/2   | host turnaround, LAD released; req_o already raised
// SYNC     | LAD shows a SYNC nibble (long wait, ready or error)
// RDATA    | LAD shows read data, low nibble then high nibble
// FTAR     | LAD shows 1111 before release
module lpc_periph_mc
  import lpc_defines::*;
#(
  parameter bit          IO_EN    = 1'b1,
  parameter bit          TPM_EN   = 1'b1,
  parameter bit          MEM_EN   = 1'b0,
  parameter logic [15:0] IO_BASE  = 16'h0000,
  parameter logic [15:0] IO_MASK  = 16'hFF00,
  parameter logic [31:0] MEM_BASE = 32'hFED4_0000,
  parameter logic [31:0] MEM_MASK = 32'hFFFF_0000,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lframe_i,
  input  logic [3:0]  lad_i,
  output logic [3:0]  lad_o,
  output logic        lad_oe,
  output logic        req_o,
  output logic        req_we_o,
  output logic [1:0]  req_type_o,
  output logic [31:0] req_addr_o,
  output logic [7:0]  req_wdata_o,
  input  logic        req_ack_i,
  input  logic        req_err_i,
  input  logic [7:0]  req_rdata_i,
  output logic        cycle_abort_o,
  output logic        timeout_o
);

  lpc_state_e  state_q, state_d;
  logic [3:0]  start_q, start_d;
  logic        we_q, we_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  ncnt_q, ncnt_d;
  logic        hi_q, hi_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [3:0]  lad_o_q, lad_o_d;
  logic        lad_oe_q, lad_oe_d;
  logic        abort_q, abort_d;
  logic        timeout_q, timeout_d;

  logic        tmr_expire;
  logic        ack_evt;
  logic        claimed;

  assign ack_evt = req_q && req_ack_i;
  assign claimed = (state_q != ST_IDLE) && (state_q != ST_START);

  lpc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q != ST_SYNC),
    .en_i     ((state_q == ST_SYNC) && (lad_o_q == SYNC_LWAIT)),
    .expire_o (tmr_expire)
  );

  // next-state, provider handshake and next LAD drive
  always_comb begin
    logic [31:0] addr_next;
    logic        hit;
    state_d   = state_q;
    start_d   = start_q;
    we_d      = we_q;
    type_d    = type_q;
    addr_d    = addr_q;
    ncnt_d    = ncnt_q;
    hi_d      = hi_q;
    wdata_d   = wdata_q;
    req_d     = req_q;
    ack_d     = ack_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    lad_o_d   = 4'h0;
    lad_oe_d  = 1'b0;
    abort_d   = 1'b0;
    timeout_d = 1'b0;
    addr_next = {addr_q[27:0], lad_i};
    hit       = 1'b0;

    // the ack is latched in whichever state it arrives while req_o is high
    if (ack_evt) begin
      req_d   = 1'b0;
      ack_d   = 1'b1;
      err_d   = req_err_i;
      rdata_d = req_err_i ? 8'hFF : req_rdata_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (!lframe_i && valid_start(lad_i)) begin
          state_d = ST_START;
          start_d = lad_i;
        end
      end
      ST_START: begin
        if (!lframe_i) begin
          if (valid_start(lad_i)) start_d = lad_i;
          else                    state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
          if ((IO_EN && start_q == START_LPC && lad_i[3:2] == CT_IO) ||
              (TPM_EN && start_q == START_TPM && lad_i[3:2] == CT_IO) ||
              (MEM_EN && start_q == START_LPC && lad_i[3:2] == CT_MEM)) begin
            state_d = ST_ADDR;
            we_d    = lad_i[1];
            addr_d  = '0;
            wdata_d = '0;
            ack_d   = 1'b0;
            err_d   = 1'b0;
            rdata_d = '0;
            hi_d    = 1'b0;
            if (lad_i[3:2] == CT_MEM) begin
              type_d = RT_MEM;
              ncnt_d = 3'd7;
            end else begin
              type_d = (start_q == START_TPM) ? RT_TPM : RT_IO;
              ncnt_d = 3'd3;
            end
          end
        end
      end
      ST_ADDR: begin
        addr_d = addr_next;
        if (ncnt_q == 3'd0) begin
          if (type_q == RT_IO)       hit = (addr_next[15:0] & IO_MASK) == (IO_BASE & IO_MASK);
          else if (type_q == RT_TPM) hit = 1'b1;
          else                       hit = (addr_next & MEM_MASK) == (MEM_BASE & MEM_MASK);
          if (!hit) begin
            state_d = ST_IDLE;
          end else if (we_q) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_TAR1;
            req_d   = 1'b1;
          end
        end else begin
          ncnt_d = ncnt_q - 3'd1;
        end
      end
      ST_WDATA: begin
        if (!hi_q) begin
          wdata_d[3:0] = lad_i;
          hi_d         = 1'b1;
        end else begin
          wdata_d[7:4] = lad_i;
          hi_d         = 1'b0;
          state_d      = ST_TAR1;
          req_d        = 1'b1;
        end
      end
      ST_TAR1: state_d = ST_TAR2;
      ST_TAR2: begin
        state_d  = ST_SYNC;
        lad_oe_d = 1'b1;
        lad_o_d  = ack_d ? (err_d ? SYNC_ERR : SYNC_READY) : SYNC_LWAIT;
      end
      ST_SYNC: begin
        lad_oe_d = 1'b1;
        if (lad_o_q == SYNC_LWAIT) begin
          if (ack_d) begin
            lad_o_d = err_d ? SYNC_ERR : SYNC_READY;
          end else if (tmr_expire) begin
            // dropping req_o tells the provider the access is cancelled
            lad_o_d   = SYNC_ERR;
            timeout_d = 1'b1;
            req_d     = 1'b0;
            ack_d     = 1'b1;
            err_d     = 1'b1;
            rdata_d   = 8'hFF;
          end else begin
            lad_o_d = SYNC_LWAIT;
          end
        end else if (we_q) begin
          state_d = ST_FTAR;
          lad_o_d = LAD_TAR;
        end else begin
          state_d = ST_RDATA;
          lad_o_d = rdata_q[3:0];
          hi_d    = 1'b0;
        end
      end
      ST_RDATA: begin
        lad_oe_d = 1'b1;
        if (!hi_q) begin
          lad_o_d = rdata_q[7:4];
          hi_d    = 1'b1;
        end else begin
          state_d = ST_FTAR;
          lad_o_d = LAD_TAR;
          hi_d    = 1'b0;
        end
      end
      ST_FTAR: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // LFRAME# during a claimed cycle overrides everything, including an ack
    if (!lframe_i && claimed) begin
      abort_d   = 1'b1;
      req_d     = 1'b0;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      timeout_d = 1'b0;
      lad_oe_d  = 1'b0;
      lad_o_d   = 4'h0;
      hi_d      = 1'b0;
      if (valid_start(lad_i)) begin
        state_d = ST_START;
        start_d = lad_i;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      start_q   <= '0;
      we_q      <= 1'b0;
      type_q    <= '0;
      addr_q    <= '0;
      ncnt_q    <= '0;
      hi_q      <= 1'b0;
      wdata_q   <= '0;
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      lad_o_q   <= '0;
      lad_oe_q  <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      we_q      <= we_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      ncnt_q    <= ncnt_d;
      hi_q      <= hi_d;
      wdata_q   <= wdata_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      lad_o_q   <= lad_o_d;
      lad_oe_q  <= lad_oe_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

  assign lad_o         = lad_o_q;
  assign lad_oe        = lad_oe_q;
  assign req_o         = req_q;
  assign req_we_o      = we_q;
  assign req_type_o    = type_q;
  assign req_addr_o    = addr_q;
  assign req_wdata_o   = wdata_q;
  assign cycle_abort_o = abort_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_lpc_periph_mc.sv
// Bench for lpc_periph_mc: a host driver issues LPC cycles and pushes the
// expected LAD nibbles / request fields / pulses into queues; a negedge
// monitor pops and compares whenever a DUT presents one of those outputs.
module tb_lpc_periph_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        lframe_i, lframe_m;
  logic [3:0]  lad_i, lad_m;
  logic        ack_i, ack_m, err_i;
  logic [7:0]  rdata_i;

  logic [3:0]  lad_o, lad_o_m;
  logic        lad_oe, lad_oe_m, req, req_m, we, we_m;
  logic [1:0]  ty, ty_m;
  logic [31:0] addr, addr_m;
  logic [7:0]  wd, wd_m;
  logic        abt, abt_m, tmo, tmo_m;

  lpc_periph_mc dut (
    .clk_i(clk), .rst_i(rst_i), .lframe_i(lframe_i), .lad_i(lad_i),
    .lad_o(lad_o), .lad_oe(lad_oe), .req_o(req), .req_we_o(we),
    .req_type_o(ty), .req_addr_o(addr), .req_wdata_o(wd),
    .req_ack_i(ack_i), .req_err_i(err_i), .req_rdata_i(rdata_i),
    .cycle_abort_o(abt), .timeout_o(tmo)
  );

  lpc_periph_mc #(.MEM_EN(1'b1), .MAX_WAIT(4)) dut_m (
    .clk_i(clk), .rst_i(rst_i), .lframe_i(lframe_m), .lad_i(lad_m),
    .lad_o(lad_o_m), .lad_oe(lad_oe_m), .req_o(req_m), .req_we_o(we_m),
    .req_type_o(ty_m), .req_addr_o(addr_m), .req_wdata_o(wd_m),
    .req_ack_i(ack_m), .req_err_i(err_i), .req_rdata_i(rdata_i),
    .cycle_abort_o(abt_m), .timeout_o(tmo_m)
  );

  int checks = 0;
  int failures = 0;
  logic sel = 1'b0;

  logic [3:0]  q_lad[$], q_lad_m[$];
  logic [42:0] q_req[$], q_req_m[$];
  logic [1:0]  q_abt[$];
  logic [4:0]  q_tmo[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [63:0] got);
    checks++;
    failures++;
    $display("FAIL %s got=%0h exp=nothing", nm, got);
  endtask

  logic req_prev = 1'b0, req_prev_m = 1'b0;

  // monitor: pop and compare whenever a DUT presents an output
  always @(negedge clk) begin
    if (lad_oe) begin
      if (q_lad.size() == 0) unexp("lad_drive", {60'h0, lad_o});
      else chk("lad_nibble", {60'h0, lad_o}, {60'h0, q_lad.pop_front()});
    end
    if (lad_oe_m) begin
      if (q_lad_m.size() == 0) unexp("lad_drive_m", {60'h0, lad_o_m});
      else chk("lad_nibble_m", {60'h0, lad_o_m}, {60'h0, q_lad_m.pop_front()});
    end
    if (req && !req_prev) begin
      if (q_req.size() == 0) unexp("req_rise", {21'h0, we, ty, addr, wd});
      else chk("req_fields", {21'h0, we, ty, addr, wd}, {21'h0, q_req.pop_front()});
    end
    if (req_m && !req_prev_m) begin
      if (q_req_m.size() == 0) unexp("req_rise_m", {21'h0, we_m, ty_m, addr_m, wd_m});
      else chk("req_fields_m", {21'h0, we_m, ty_m, addr_m, wd_m}, {21'h0, q_req_m.pop_front()});
    end
    if (abt) begin
      if (q_abt.size() == 0) unexp("abort_pulse", {62'h0, lad_oe, req});
      else chk("abort_state", {62'h0, lad_oe, req}, {62'h0, q_abt.pop_front()});
    end
    if (abt_m) unexp("abort_pulse_m", 64'h1);
    if (tmo) unexp("timeout_pulse", 64'h1);
    if (tmo_m) begin
      if (q_tmo.size() == 0) unexp("timeout_pulse_m", {59'h0, req_m, lad_o_m});
      else chk("timeout_state_m", {59'h0, req_m, lad_o_m}, {59'h0, q_tmo.pop_front()});
    end
    req_prev   <= req;
    req_prev_m <= req_m;
  end

  task automatic drv(input logic lf, input logic [3:0] n);
    if (sel) begin lframe_m = lf; lad_m = n; end
    else     begin lframe_i = lf; lad_i = n; end
    @(posedge clk); #1;
  endtask

  // one host cycle; k indexes clocks after req_o would rise (k=0 is TAR1)
  task automatic run_cycle(input logic [3:0] st, input logic skip_start,
                           input logic [3:0] ct, input logic [31:0] a, input int nn,
                           input logic [7:0] wdat, input int tail, input int ack_k,
                           input logic err, input logic [7:0] rd, input int req_last,
                           input int abort_k, input int rst_k);
    if (!skip_start) drv(1'b0, st);
    drv(1'b1, ct);
    for (int i = 0; i < nn; i++) drv(1'b1, a[4*(nn-1-i) +: 4]);
    if (ct[1]) begin
      drv(1'b1, wdat[3:0]);
      drv(1'b1, wdat[7:4]);
    end
    for (int k = 0; k < tail; k++) begin
      err_i   = err;
      rdata_i = rd;
      if (sel) ack_m = (k == ack_k);
      else     ack_i = (k == ack_k);
      if (k == rst_k) rst_i = 1'b1;
      if (k == abort_k) drv(1'b0, 4'b0000);
      else              drv(1'b1, 4'hF);
      ack_i = 1'b0;
      ack_m = 1'b0;
      chk("req_hold", {63'h0, (sel ? req_m : req)}, {63'h0, (k < req_last)});
      if (k == abort_k || k == rst_k) break;
    end
    lframe_i = 1'b1; lad_i = 4'hF;
    lframe_m = 1'b1; lad_m = 4'hF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    lframe_i = 1'b1; lad_i = 4'hF;
    lframe_m = 1'b1; lad_m = 4'hF;
    ack_i = 1'b0; ack_m = 1'b0; err_i = 1'b0; rdata_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {13'h0, lad_o, lad_oe, req, we, ty, addr, wd, abt, tmo}, 64'h0);
    chk("reset_outputs_m", {13'h0, lad_o_m, lad_oe_m, req_m, we_m, ty_m, addr_m, wd_m, abt_m, tmo_m}, 64'h0);
    rst_i = 1'b0;

    // I/O read 0x0080, ack in TAR1 with A5
    q_req.push_back({1'b0, 2'b00, 32'h0000_0080, 8'h00});
    q_lad.push_back(4'h0); q_lad.push_back(4'h5); q_lad.push_back(4'hA); q_lad.push_back(4'hF);
    run_cycle(4'b0000, 1'b0, 4'b0000, 32'h0080, 4, 8'h00, 7, 0, 1'b0, 8'hA5, 0, -1, -1);

    // TPM write 0x0F00 data 3C, ack in fifth SYNC clock
    q_req.push_back({1'b1, 2'b01, 32'h0000_0F00, 8'h3C});
    for (int i = 0; i < 5; i++) q_lad.push_back(4'h6);
    q_lad.push_back(4'h0); q_lad.push_back(4'hF);
    run_cycle(4'b0101, 1'b0, 4'b0010, 32'h0F00, 4, 8'h3C, 10, 6, 1'b0, 8'h00, 6, -1, -1);

    // I/O read 0x0300 outside the window: nothing expected
    run_cycle(4'b0000, 1'b0, 4'b0000, 32'h0300, 4, 8'h00, 4, -1, 1'b0, 8'h00, -1, -1, -1);

    // memory read 0xFED40024 on the MAX_WAIT=4 instance, no ack, late ack ignored
    sel = 1'b1;
    q_req_m.push_back({1'b0, 2'b10, 32'hFED4_0024, 8'h00});
    for (int i = 0; i < 4; i++) q_lad_m.push_back(4'h6);
    q_lad_m.push_back(4'hA);
    q_lad_m.push_back(4'hF); q_lad_m.push_back(4'hF); q_lad_m.push_back(4'hF);
    q_tmo.push_back({1'b0, 4'hA});
    run_cycle(4'b0000, 1'b0, 4'b0100, 32'hFED4_0024, 8, 8'h00, 11, 7, 1'b0, 8'h00, 5, -1, -1);
    sel = 1'b0;

    // I/O write 0x0010, abort with START 0000 during second SYNC clock
    q_req.push_back({1'b1, 2'b00, 32'h0000_0010, 8'h55});
    q_lad.push_back(4'h6); q_lad.push_back(4'h6);
    q_abt.push_back(2'b00);
    run_cycle(4'b0000, 1'b0, 4'b0010, 32'h0010, 4, 8'h55, 10, -1, 1'b0, 8'h00, 3, 3, -1);

    // DUT now sits in START: cyctype follows directly, I/O read 0x0081 -> 5A
    q_req.push_back({1'b0, 2'b00, 32'h0000_0081, 8'h00});
    q_lad.push_back(4'h6); q_lad.push_back(4'h0);
    q_lad.push_back(4'hA); q_lad.push_back(4'h5); q_lad.push_back(4'hF);
    run_cycle(4'b0000, 1'b1, 4'b0000, 32'h0081, 4, 8'h00, 8, 2, 1'b0, 8'h5A, 2, -1, -1);

    // I/O read 0x0040, reset during first RDATA clock
    q_req.push_back({1'b0, 2'b00, 32'h0000_0040, 8'h00});
    q_lad.push_back(4'h0); q_lad.push_back(4'h1);
    run_cycle(4'b0000, 1'b0, 4'b0000, 32'h0040, 4, 8'h00, 10, 0, 1'b0, 8'h21, 0, -1, 3);
    chk("midreset_outputs", {13'h0, lad_o, lad_oe, req, we, ty, addr, wd, abt, tmo}, 64'h0);
    rst_i = 1'b0;

    // I/O write 0x0090 data E7 after the reset, ack in second SYNC clock
    q_req.push_back({1'b1, 2'b00, 32'h0000_0090, 8'hE7});
    q_lad.push_back(4'h6); q_lad.push_back(4'h6); q_lad.push_back(4'h0); q_lad.push_back(4'hF);
    run_cycle(4'b0000, 1'b0, 4'b0010, 32'h0090, 4, 8'hE7, 7, 3, 1'b0, 8'h00, 3, -1, -1);

    repeat (4) @(posedge clk);
    #1;
    chk("lad_queue_left", q_lad.size(), 64'h0);
    chk("lad_queue_left_m", q_lad_m.size(), 64'h0);
    chk("req_queue_left", q_req.size(), 64'h0);
    chk("req_queue_left_m", q_req_m.size(), 64'h0);
    chk("abort_queue_left", q_abt.size(), 64'h0);
    chk("timeout_queue_left", q_tmo.size(), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
